reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-port integer register file with a built-in scoreboard for long-latency results, for the RV32IM pipeline. It has two write ports: one for pipeline writeback and one for multiply/divide returns. It tracks which registers still await a long-latency result and reports this per read port so decode can stall. Same-cycle write-to-read bypass and a debug read port are included for FPGA bring-up.

## Interface
Parameters:
- XLEN, 32: register width in bits.
- NREGS, 32: number of registers (power of two, ≥ 2). AW = $clog2(NREGS).
- NREAD, 2: number of read ports (1..4).
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching read ports.
- ZERO_REG, 1: 1 = register 0 reads as zero, ignores writes, and is never busy.

Ports:
- CLK, in, 1: single clock, rising edge.
- RESET, in, 1: asynchronous, active-high reset.
- RADDR, in, NREAD*AW: packed read addresses; port k is bits [k*AW +: AW].
- RDATA, out, NREAD*XLEN: packed read data.
- RBUSY, out, NREAD: busy bit of the register addressed by each read port.
- W0_EN / W0_ADDR / W0_DATA, in, 1/AW/XLEN: pipeline writeback port.
- W1_EN / W1_ADDR / W1_DATA, in, 1/AW/XLEN: long-latency return port; also clears busy.
- ISSUE_EN / ISSUE_ADDR, in, 1/AW: a long-latency op is issued with this destination; sets busy.
- BUSY_COUNT, out, AW+1: number of registers currently busy.
- ERR, out, 1: sticky protocol-violation flag.
- DEBUG_ADDR, in, AW: debug read address. DEBUG_DATA, out, XLEN: unbypassed register contents.
- DEBUG_BUSY, out, NREGS: full busy vector.

## Operation
- Storage: NREGS×XLEN array. RESET clears all registers, all busy bits, BUSY_COUNT and ERR to 0, asynchronously.
- Writes occur at the rising edge when the port's EN is high.
- W0 and W1 to the same address in the same cycle: W0 data is stored, W1 still clears busy, and ERR is set.
- ZERO_REG=1: writes and issues to address 0 are dropped silently, with no ERR.
- Read port k, combinational: RDATA_k = stored[RADDR_k]. When BYPASS=1, priority is W0 match > W1 match > stored. Register 0 always reads 0 when ZERO_REG=1.
- Busy state update at the edge, per register r:
  - busy_next = (ISSUE_EN && ISSUE_ADDR==r) || (busy && !(W1_EN && W1_ADDR==r)).
  - If issue and clear hit the same register in the same cycle, set wins.
- RBUSY_k = busy[RADDR_k]. When BYPASS=1, it is masked to 0 if W1 clears that register this cycle.
- BUSY_COUNT tracks the number of set busy bits, updated incrementally by +1, −1, or 0 per cycle. It never exceeds NREGS−ZERO_REG.
- ERR is set and held until reset on:
  - ISSUE to an already-busy register (a WAW hazard that decode should have stalled); the busy bit stays 1 and the count is unchanged.
  - W1 write to a non-busy register; the data is still written.
  - Simultaneous W0/W1 address collision.

## Timing
- Write latency: data is visible to reads in the same cycle with BYPASS=1, or in the next cycle with BYPASS=0. DEBUG_DATA always lags by one cycle.
- Busy set latency: RBUSY rises in the cycle after ISSUE_EN.
- Busy clear latency: RBUSY falls in the same cycle as the W1 write with BYPASS=1, otherwise in the next cycle.
- All outputs are combinational from state and inputs; there is no registered-output latency.
- Reset asserted mid-operation discards pending busy bits immediately; in-flight W1 returns after reset raise ERR.

## Structure
- reg_file_pkg holds:
  - default parameter constants (XLEN, NREGS, NREAD);
  - the function for addr_width;
  - the ERR cause encoding, for the debug monitor.
- One sub-module, reg_scoreboard, owns the busy vector, BUSY_COUNT, ERR and the issue/clear/collision logic. The top level holds the data array, read muxes and bypass.

## Test plan
- Reset, then write 0xDEADBEEF to x5 via W0 and read x5 on both ports in the same cycle → 0xDEADBEEF when BYPASS=1; the previous value (0) when BYPASS=0, then 0xDEADBEEF next cycle.
- W0 writes 0x1234 to x0 (ZERO_REG=1) → x0 reads 0, ERR stays 0.
- ISSUE x7; next cycle RBUSY for x7 = 1 and BUSY_COUNT = 1; W1 returns 0x55 to x7 → same-cycle RBUSY = 0 and RDATA = 0x55, then BUSY_COUNT = 0.
- ISSUE x3 and W1 to x3 in the same cycle, with x3 already busy → x3 remains busy, BUSY_COUNT unchanged, ERR = 0.
- ISSUE x9 twice → ERR = 1 and BUSY_COUNT = 1. W0 and W1 both to x4 → x4 holds the W0 data.
- Issue x1..x31, then assert RESET mid-run → BUSY_COUNT, DEBUG_BUSY, ERR and all registers read 0 immediately.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the reg_file_sb register file.
//   XLEN_DEF / NREGS_DEF / NREAD_DEF : default parameter values
//   addr_width()                     : register-address width for a register count
//   err_cause_e                      : first protocol violation seen, for the debug monitor
package reg_file_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int NREAD_DEF = 2;

  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_WAW     = 2'd1,  // issue to a register that is already busy
    ERR_W1_IDLE = 2'd2,  // long-latency return to a register that is not busy
    ERR_COLLIDE = 2'd3   // W0 and W1 target the same register in one cycle
  } err_cause_e;

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle of reg_file_sb: read ports, both write ports, issue port, debug
// port and the scoreboard status outputs. The master side (pipeline / bench)
// drives addresses, enables and write data; the slave side (the register file)
// drives read data, busy information and the error flag.
// Handshake note: there is no valid/ready pair; every *_EN is a single-cycle
// qualifier sampled at the rising clock edge, and the register file can never
// push back. Decode is expected to stall on RBUSY instead.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int NREAD = NREAD_DEF
) ();
  localparam int AW = addr_width(NREGS);

  logic [NREAD*AW-1:0]   RADDR;
  logic [NREAD*XLEN-1:0] RDATA;
  logic [NREAD-1:0]      RBUSY;
  logic                  W0_EN;
  logic [AW-1:0]         W0_ADDR;
  logic [XLEN-1:0]       W0_DATA;
  logic                  W1_EN;
  logic [AW-1:0]         W1_ADDR;
  logic [XLEN-1:0]       W1_DATA;
  logic                  ISSUE_EN;
  logic [AW-1:0]         ISSUE_ADDR;
  logic [AW:0]           BUSY_COUNT;
  logic                  ERR;
  err_cause_e            ERR_CAUSE;
  logic [AW-1:0]         DEBUG_ADDR;
  logic [XLEN-1:0]       DEBUG_DATA;
  logic [NREGS-1:0]      DEBUG_BUSY;

  modport master (
    output RADDR, W0_EN, W0_ADDR, W0_DATA, W1_EN, W1_ADDR, W1_DATA,
           ISSUE_EN, ISSUE_ADDR, DEBUG_ADDR,
    input  RDATA, RBUSY, BUSY_COUNT, ERR, ERR_CAUSE, DEBUG_DATA, DEBUG_BUSY
  );

  modport slave (
    input  RADDR, W0_EN, W0_ADDR, W0_DATA, W1_EN, W1_ADDR, W1_DATA,
           ISSUE_EN, ISSUE_ADDR, DEBUG_ADDR,
    output RDATA, RBUSY, BUSY_COUNT, ERR, ERR_CAUSE, DEBUG_DATA, DEBUG_BUSY
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Busy tracking for long-latency destinations.
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   issue_en_i/addr_i     : long-latency op issued, sets busy
//   w1_en_i/addr_i        : long-latency return, clears busy
//   w0_en_i/addr_i        : pipeline writeback, only used for collision detect
//   busy_o, count_o       : busy vector and its population count
//   err_o, err_cause_o    : sticky violation flag and the first cause seen
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int AW       = addr_width(NREGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_en_i,
  input  logic [AW-1:0]    issue_addr_i,
  input  logic             w1_en_i,
  input  logic [AW-1:0]    w1_addr_i,
  input  logic             w0_en_i,
  input  logic [AW-1:0]    w0_addr_i,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      count_o,
  output logic             err_o,
  output err_cause_e       err_cause_o
);
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;
  logic             err_q, err_d;
  err_cause_e       cause_q, cause_d;

  logic iss, clr, wr0, inc, dec, waw, idle, coll;

  always_comb begin
    // Accesses to x0 are dropped before they reach any bookkeeping.
    iss  = issue_en_i && !((ZERO_REG != 0) && (issue_addr_i == '0));
    clr  = w1_en_i    && !((ZERO_REG != 0) && (w1_addr_i    == '0));
    wr0  = w0_en_i    && !((ZERO_REG != 0) && (w0_addr_i    == '0));

    busy_d = busy_q;
    if (clr) busy_d[w1_addr_i]    = 1'b0;
    if (iss) busy_d[issue_addr_i] = 1'b1;  // set wins over a same-cycle clear

    inc  = iss && !busy_q[issue_addr_i];
    dec  = clr &&  busy_q[w1_addr_i] && !(iss && (issue_addr_i == w1_addr_i));
    // Re-issuing a register whose result returns this very cycle is legal.
    waw  = iss &&  busy_q[issue_addr_i] && !(clr && (w1_addr_i == issue_addr_i));
    idle = clr && !busy_q[w1_addr_i];
    coll = wr0 && clr && (w0_addr_i == w1_addr_i);

    count_d = count_q + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};

    err_d   = err_q | coll | waw | idle;
    cause_d = cause_q;
    if (!err_q) begin
      if (coll)      cause_d = ERR_COLLIDE;
      else if (waw)  cause_d = ERR_WAW;
      else if (idle) cause_d = ERR_W1_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      cause_q <= ERR_NONE;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
      cause_q <= cause_d;
    end
  end

  assign busy_o      = busy_q;
  assign count_o     = count_q;
  assign err_o       = err_q;
  assign err_cause_o = cause_q;
endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with long-latency scoreboard.
//   CLK, RESET : clock, asynchronous active-high reset
//   bus        : reg_file_sb_if slave port -- NREAD combinational read ports
//                with optional same-cycle bypass (W0 > W1 > stored), pipeline
//                writeback W0, long-latency return W1, issue port, busy/error
//                status and an unbypassed debug read port.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NREAD    = NREAD_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input logic          CLK,
  input logic          RESET,
  reg_file_sb_if.slave bus
);
  localparam int AW = addr_width(NREGS);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr0, wr1;

  assign wr0 = bus.W0_EN && !((ZERO_REG != 0) && (bus.W0_ADDR == '0));
  assign wr1 = bus.W1_EN && !((ZERO_REG != 0) && (bus.W1_ADDR == '0));

  // W0 wins a same-address collision; the scoreboard flags it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      if (wr1) mem_q[bus.W1_ADDR] <= bus.W1_DATA;
      if (wr0) mem_q[bus.W0_ADDR] <= bus.W0_DATA;
    end
  end

  reg_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_sb (
    .clk_i        (CLK),
    .rst_i        (RESET),
    .issue_en_i   (bus.ISSUE_EN),
    .issue_addr_i (bus.ISSUE_ADDR),
    .w1_en_i      (bus.W1_EN),
    .w1_addr_i    (bus.W1_ADDR),
    .w0_en_i      (bus.W0_EN),
    .w0_addr_i    (bus.W0_ADDR),
    .busy_o       (busy),
    .count_o      (bus.BUSY_COUNT),
    .err_o        (bus.ERR),
    .err_cause_o  (bus.ERR_CAUSE)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            w1_hit;

    assign rd_addr = bus.RADDR[k*AW +: AW];
    assign w1_hit  = (BYPASS != 0) && wr1 && (bus.W1_ADDR == rd_addr);

    always_comb begin
      rd_data = mem_q[rd_addr];
      if (w1_hit) rd_data = bus.W1_DATA;
      if ((BYPASS != 0) && wr0 && (bus.W0_ADDR == rd_addr)) rd_data = bus.W0_DATA;
      if ((ZERO_REG != 0) && (rd_addr == '0)) rd_data = '0;
    end

    assign bus.RDATA[k*XLEN +: XLEN] = rd_data;
    // A result returning this cycle is already forwarded, so don't stall on it.
    assign bus.RBUSY[k] = busy[rd_addr] & ~w1_hit;
  end

  assign bus.DEBUG_BUSY = busy;
  assign bus.DEBUG_DATA = mem_q[bus.DEBUG_ADDR];
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  import reg_file_pkg::*;

  logic CLK;
  logic RESET;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  reg_file_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_b ();
  reg_file_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) bus_n ();

  // Bypassed instance
  reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .ZERO_REG(1)) u_dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_b.slave)
  );

  // Unbypassed instance, fed the same stimulus
  reg_file_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_n.slave)
  );

  assign bus_n.RADDR      = bus_b.RADDR;
  assign bus_n.W0_EN      = bus_b.W0_EN;
  assign bus_n.W0_ADDR    = bus_b.W0_ADDR;
  assign bus_n.W0_DATA    = bus_b.W0_DATA;
  assign bus_n.W1_EN      = bus_b.W1_EN;
  assign bus_n.W1_ADDR    = bus_b.W1_ADDR;
  assign bus_n.W1_DATA    = bus_b.W1_DATA;
  assign bus_n.ISSUE_EN   = bus_b.ISSUE_EN;
  assign bus_n.ISSUE_ADDR = bus_b.ISSUE_ADDR;
  assign bus_n.DEBUG_ADDR = bus_b.DEBUG_ADDR;

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic idle_inputs();
    bus_b.W0_EN = 1'b0;  bus_b.W0_ADDR = '0;  bus_b.W0_DATA = '0;
    bus_b.W1_EN = 1'b0;  bus_b.W1_ADDR = '0;  bus_b.W1_DATA = '0;
    bus_b.ISSUE_EN = 1'b0;  bus_b.ISSUE_ADDR = '0;
  endtask

  task automatic set_raddr(input logic [4:0] a0, input logic [4:0] a1);
    bus_b.RADDR = {a1, a0};
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic w0(input logic [4:0] a, input logic [31:0] d);
    bus_b.W0_EN = 1'b1; bus_b.W0_ADDR = a; bus_b.W0_DATA = d;
  endtask

  task automatic w1(input logic [4:0] a, input logic [31:0] d);
    bus_b.W1_EN = 1'b1; bus_b.W1_ADDR = a; bus_b.W1_DATA = d;
  endtask

  task automatic issue(input logic [4:0] a);
    bus_b.ISSUE_EN = 1'b1; bus_b.ISSUE_ADDR = a;
  endtask

  initial begin
    RESET = 1'b1;
    idle_inputs();
    set_raddr(5'd0, 5'd0);
    bus_b.DEBUG_ADDR = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    #1;

    // reset state
    check("rst_count", 64'(bus_b.BUSY_COUNT), 64'd0);
    check("rst_err",   64'(bus_b.ERR),        64'd0);
    check("rst_busy",  64'(bus_b.DEBUG_BUSY), 64'd0);

    // same-cycle W0 bypass to x5 on both ports
    set_raddr(5'd5, 5'd5);
    w0(5'd5, 32'hDEADBEEF);
    #1;
    check("byp_p0",    64'(bus_b.RDATA[31:0]),  64'hDEADBEEF);
    check("byp_p1",    64'(bus_b.RDATA[63:32]), 64'hDEADBEEF);
    check("nobyp_old", 64'(bus_n.RDATA[31:0]),  64'd0);
    tick();
    idle_inputs();
    bus_b.DEBUG_ADDR = 5'd5;
    #1;
    check("nobyp_new", 64'(bus_n.RDATA[63:32]), 64'hDEADBEEF);
    check("dbg_x5",    64'(bus_b.DEBUG_DATA),   64'hDEADBEEF);

    // writes to x0 are dropped silently
    set_raddr(5'd0, 5'd5);
    w0(5'd0, 32'h1234);
    #1;
    check("x0_byp", 64'(bus_b.RDATA[31:0]), 64'd0);
    tick();
    idle_inputs();
    #1;
    check("x0_read", 64'(bus_n.RDATA[31:0]), 64'd0);
    check("x0_err",  64'(bus_b.ERR),         64'd0);

    // issue x7, then long-latency return
    set_raddr(5'd7, 5'd5);
    issue(5'd7);
    #1;
    check("x7_pre_busy", 64'(bus_b.RBUSY[0]), 64'd0);
    tick();
    idle_inputs();
    #1;
    check("x7_busy",  64'(bus_b.RBUSY[0]),   64'd1);
    check("x7_count", 64'(bus_b.BUSY_COUNT), 64'd1);
    w1(5'd7, 32'h55);
    #1;
    check("x7_clr_byp",   64'(bus_b.RBUSY[0]),     64'd0);
    check("x7_data_byp",  64'(bus_b.RDATA[31:0]),  64'h55);
    check("x7_busy_nb",   64'(bus_n.RBUSY[0]),     64'd1);
    tick();
    idle_inputs();
    #1;
    check("x7_count0", 64'(bus_b.BUSY_COUNT), 64'd0);
    check("x7_clr_nb", 64'(bus_n.RBUSY[0]),   64'd0);
    check("x7_err",    64'(bus_b.ERR),        64'd0);

    // issue and return on an already-busy x3 in the same cycle
    set_raddr(5'd3, 5'd5);
    issue(5'd3);
    tick();
    issue(5'd3);
    w1(5'd3, 32'h33);
    tick();
    idle_inputs();
    #1;
    check("x3_busy",  64'(bus_b.RBUSY[0]),   64'd1);
    check("x3_count", 64'(bus_b.BUSY_COUNT), 64'd1);
    check("x3_err",   64'(bus_b.ERR),        64'd0);
    check("x3_data",  64'(bus_b.RDATA[31:0]), 64'h33);
    w1(5'd3, 32'h34);
    tick();
    idle_inputs();
    #1;
    check("x3_count0", 64'(bus_b.BUSY_COUNT), 64'd0);
    check("x3_err2",   64'(bus_b.ERR),        64'd0);

    // WAW: issue x9 twice
    issue(5'd9);
    tick();
    issue(5'd9);
    tick();
    idle_inputs();
    #1;
    check("waw_err",   64'(bus_b.ERR),        64'd1);
    check("waw_count", 64'(bus_b.BUSY_COUNT), 64'd1);
    check("waw_cause", 64'(bus_b.ERR_CAUSE),  64'(ERR_WAW));

    // W0 / W1 collision on x4: W0 data wins
    set_raddr(5'd4, 5'd4);
    w0(5'd4, 32'hAAAA);
    w1(5'd4, 32'hBBBB);
    #1;
    check("coll_byp", 64'(bus_b.RDATA[31:0]), 64'hAAAA);
    tick();
    idle_inputs();
    bus_b.DEBUG_ADDR = 5'd4;
    #1;
    check("coll_data",  64'(bus_b.DEBUG_DATA), 64'hAAAA);
    check("coll_cause", 64'(bus_b.ERR_CAUSE),  64'(ERR_WAW));

    // fresh start, then issue to every register
    RESET = 1'b1;
    #1 RESET = 1'b0;
    #1;
    check("rst2_err", 64'(bus_b.ERR), 64'd0);
    for (int r = 0; r < 32; r++) begin
      issue(5'(r));
      tick();
    end
    idle_inputs();
    #1;
    check("all_count", 64'(bus_b.BUSY_COUNT), 64'd31);
    check("all_busy",  64'(bus_b.DEBUG_BUSY), 64'hFFFF_FFFE);
    check("all_err",   64'(bus_b.ERR),        64'd0);

    // asynchronous reset mid-cycle, then a stale W1 return
    w0(5'd6, 32'h600D);
    tick();
    idle_inputs();
    #2;
    RESET = 1'b1;
    set_raddr(5'd6, 5'd4);
    bus_b.DEBUG_ADDR = 5'd6;
    #1;
    check("arst_count", 64'(bus_b.BUSY_COUNT),    64'd0);
    check("arst_busy",  64'(bus_b.DEBUG_BUSY),    64'd0);
    check("arst_err",   64'(bus_b.ERR),           64'd0);
    check("arst_x6",    64'(bus_b.RDATA[31:0]),   64'd0);
    check("arst_x4",    64'(bus_n.RDATA[63:32]),  64'd0);
    check("arst_dbg",   64'(bus_b.DEBUG_DATA),    64'd0);
    #1 RESET = 1'b0;
    w1(5'd8, 32'h88);
    tick();
    idle_inputs();
    #1;
    check("stale_err",   64'(bus_b.ERR),       64'd1);
    check("stale_cause", 64'(bus_b.ERR_CAUSE), 64'(ERR_W1_IDLE));
    check("stale_count", 64'(bus_b.BUSY_COUNT), 64'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
